// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its UART sequencer.
//   - Opcode constants understood by the ALU (6-bit function codes).
//   - State encoding of the alu_uart_interface sequencer FSM.
package alu_pkg;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StSend
  } state_e;

endpackage

// File: rtl/alu_uart_interface.sv
// Sequencer between uart_rx, a combinational ALU and uart_tx.
// Collects three received bytes as operand A, operand B and opcode, gives the
// ALU one cycle to settle, captures its result and hands it to the transmitter.
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   RX_DATA, RX_DONE    received byte and its one-cycle valid strobe
//   TX_BUSY             transmitter busy; hold off TX_START while high
//   TX_DATA, TX_START   registered result byte and one-cycle send request
//   DATOA, DATOB        registered ALU operands
//   OPCODE              registered ALU opcode (low SIZEOP bits of third byte)
//   RESULT              combinational ALU output, sampled at the end of EXEC
//   DROPPED             one-cycle pulse: a byte arrived in EXEC/SEND and was lost
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int unsigned SIZEDATA = 8,
  parameter int unsigned SIZEOP   = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [SIZEDATA-1:0] RX_DATA,
  input  logic                RX_DONE,
  input  logic                TX_BUSY,
  output logic [SIZEDATA-1:0] TX_DATA,
  output logic                TX_START,
  output logic [SIZEDATA-1:0] DATOA,
  output logic [SIZEDATA-1:0] DATOB,
  output logic [SIZEOP-1:0]   OPCODE,
  input  logic [SIZEDATA-1:0] RESULT,
  output logic                DROPPED
);

  state_e state_q, state_d;

  logic [SIZEDATA-1:0] datoa_q, datob_q, tx_data_q;
  logic [SIZEOP-1:0]   opcode_q;
  logic                tx_start_q, dropped_q;
  logic                load_a, load_b, load_op, load_tx, start_d, drop_d;

  // Upper bits of the opcode byte carry no meaning.
  logic unused_rx_hi;
  assign unused_rx_hi = ^RX_DATA[SIZEDATA-1:SIZEOP];

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    load_tx = 1'b0;
    start_d = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (RX_DONE) begin
          load_a  = 1'b1;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (RX_DONE) begin
          load_b  = 1'b1;
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        if (RX_DONE) begin
          load_op = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        // Operands have been stable for a full cycle; RESULT is settled.
        load_tx = 1'b1;
        drop_d  = RX_DONE;
        state_d = StSend;
      end
      StSend: begin
        drop_d = RX_DONE;
        if (!TX_BUSY) begin
          start_d = 1'b1;
          state_d = StWaitA;
        end
      end
      default: state_d = StWaitA;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StWaitA;
      datoa_q    <= '0;
      datob_q    <= '0;
      opcode_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= start_d;
      dropped_q  <= drop_d;
      if (load_a)  datoa_q   <= RX_DATA;
      if (load_b)  datob_q   <= RX_DATA;
      if (load_op) opcode_q  <= RX_DATA[SIZEOP-1:0];
      if (load_tx) tx_data_q <= RESULT;
    end
  end

  assign DATOA    = datoa_q;
  assign DATOB    = datob_q;
  assign OPCODE   = opcode_q;
  assign TX_DATA  = tx_data_q;
  assign TX_START = tx_start_q;
  assign DROPPED  = dropped_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed self-checking bench for alu_uart_interface. A small ALU model drives
// RESULT; expected transmit bytes are queued when the opcode byte is sent and
// checked when TX_START pulses.
module tb_alu_uart_interface;
  import alu_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] RX_DATA;
  logic       RX_DONE;
  logic       TX_BUSY;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic [7:0] DATOA, DATOB;
  logic [5:0] OPCODE;
  logic [7:0] RESULT;
  logic       DROPPED;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int op_cyc      = 0;
  int exp_lat     = 2;
  int tx_count    = 0;
  int drop_count  = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      ADD:     alu_f = a + b;
      SUB:     alu_f = a - b;
      AND:     alu_f = a & b;
      OR:      alu_f = a | b;
      XOR:     alu_f = a ^ b;
      NOR:     alu_f = ~(a | b);
      SRA:     alu_f = $signed(a) >>> b;
      SRL:     alu_f = a >> b;
      default: alu_f = 8'hFF;
    endcase
  endfunction

  assign RESULT = alu_f(DATOA, DATOB, OPCODE);

  alu_uart_interface #(.SIZEDATA(8), .SIZEOP(6)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RX_DATA  (RX_DATA),
    .RX_DONE  (RX_DONE),
    .TX_BUSY  (TX_BUSY),
    .TX_DATA  (TX_DATA),
    .TX_START (TX_START),
    .DATOA    (DATOA),
    .DATOB    (DATOB),
    .OPCODE   (OPCODE),
    .RESULT   (RESULT),
    .DROPPED  (DROPPED)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard side: every TX_START pops one expected byte.
  always @(negedge CLK) begin
    if (TX_START === 1'b1) begin
      tx_count++;
      chk("tx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("tx_data", {24'd0, TX_DATA}, {24'd0, exp_q.pop_front()});
      chk("tx_latency", cyc - op_cyc, exp_lat);
    end
    if (DROPPED === 1'b1) drop_count++;
  end

  // Drive one RX strobe; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_DATA = b;
    RX_DONE = 1'b1;
    @(posedge CLK);
    #1;
    RX_DONE = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    exp_q.push_back(alu_f(a, b, op[5:0]));
    send(op);
    op_cyc = cyc;
  endtask

  task automatic wait_tx(input int max_cycles);
    int start = tx_count;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge CLK);
      #1;
      if (tx_count != start) break;
    end
    chk("tx_start_seen", 32'(tx_count != start), 32'd1);
  endtask

  task automatic chk_all_zero();
    chk("rst_datoa", {24'd0, DATOA}, 32'd0);
    chk("rst_datob", {24'd0, DATOB}, 32'd0);
    chk("rst_opcode", {26'd0, OPCODE}, 32'd0);
    chk("rst_tx_data", {24'd0, TX_DATA}, 32'd0);
    chk("rst_tx_start", {31'd0, TX_START}, 32'd0);
    chk("rst_dropped", {31'd0, DROPPED}, 32'd0);
  endtask

  initial begin
    int tx0, drop0;
    RESET   = 1'b1;
    RX_DATA = '0;
    RX_DONE = 1'b0;
    TX_BUSY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk_all_zero();

    // ADD 7 + 2, unloaded transmitter.
    tx0 = tx_count;
    send(8'd7);
    chk("add_datoa", {24'd0, DATOA}, 32'd7);
    send(8'd2);
    chk("add_datob", {24'd0, DATOB}, 32'd2);
    exp_lat = 2;
    send_op(8'd7, 8'd2, 8'h20);
    chk("add_opcode", {26'd0, OPCODE}, {26'd0, ADD});
    wait_tx(10);
    @(posedge CLK);
    #1;
    chk("tx_start_width", {31'd0, TX_START}, 32'd0);
    chk("add_tx_data", {24'd0, TX_DATA}, 32'd9);
    repeat (3) @(posedge CLK);
    chk("add_single_pulse", tx_count - tx0, 32'd1);

    // SUB then SRA.
    send(8'd7);
    send(8'd2);
    send_op(8'd7, 8'd2, 8'h22);
    wait_tx(10);
    chk("sub_tx_data", {24'd0, TX_DATA}, 32'd5);
    send(8'hF0);
    send(8'd2);
    send_op(8'hF0, 8'd2, 8'h03);
    wait_tx(10);
    chk("sra_tx_data", {24'd0, TX_DATA}, 32'hFC);

    // Back-pressure: five busy cycles seen in SEND.
    tx0 = tx_count;
    send(8'h12);
    send(8'h34);
    TX_BUSY = 1'b1;
    exp_lat = 7;
    send_op(8'h12, 8'h34, 8'h26);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK);
      #1;
      chk("busy_no_start", {31'd0, TX_START}, 32'd0);
      chk("busy_tx_data", {24'd0, TX_DATA}, 32'h26);
    end
    TX_BUSY = 1'b0;
    wait_tx(5);
    repeat (3) @(posedge CLK);
    chk("busy_single_pulse", tx_count - tx0, 32'd1);

    // Strobes during EXEC and SEND are dropped.
    drop0 = drop_count;
    send(8'h10);
    send(8'h03);
    TX_BUSY = 1'b1;
    exp_lat = 3;
    send_op(8'h10, 8'h03, 8'h20);
    send(8'h55);
    chk("drop_pulse_exec", {31'd0, DROPPED}, 32'd1);
    send(8'h55);
    chk("drop_pulse_send", {31'd0, DROPPED}, 32'd1);
    TX_BUSY = 1'b0;
    chk("drop_datoa", {24'd0, DATOA}, 32'h10);
    chk("drop_datob", {24'd0, DATOB}, 32'h03);
    chk("drop_opcode", {26'd0, OPCODE}, {26'd0, ADD});
    wait_tx(5);
    chk("drop_tx_data", {24'd0, TX_DATA}, 32'h13);
    repeat (2) @(posedge CLK);
    chk("drop_count", drop_count - drop0, 32'd2);

    // Asynchronous reset mid-sequence.
    tx0 = tx_count;
    TX_BUSY = 1'b1;
    send(8'd3);
    send(8'd4);
    #2;
    RESET = 1'b1;
    #1;
    chk_all_zero();
    @(negedge CLK);
    RESET   = 1'b0;
    TX_BUSY = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("reset_no_start", tx_count - tx0, 32'd0);
    exp_lat = 2;
    send(8'd3);
    send(8'd4);
    send_op(8'd3, 8'd4, 8'h24);
    wait_tx(10);
    chk("and_tx_data", {24'd0, TX_DATA}, 32'd0);
    chk("and_single_pulse", tx_count - tx0, 32'd1);

    // Opcode byte with upper bits set.
    drop0 = drop_count;
    send(8'h0F);
    send(8'hF0);
    send_op(8'h0F, 8'hF0, 8'hC6);
    chk("c6_opcode", {26'd0, OPCODE}, 32'h06);
    wait_tx(10);
    chk("c6_tx_data", {24'd0, TX_DATA}, 32'hFF);
    repeat (3) @(posedge CLK);
    chk("c6_no_drop", drop_count - drop0, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
